// File: rtl/gpio_bus_pkg.sv
// Shared types and constants for the GPIO peripheral bus arbiter.
// Register offsets mirror the multi_gpio slave map.
package gpio_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    localparam logic [31:0] GPIO_DATA_OFS = 32'h0;
    localparam logic [31:0] GPIO_DIR_OFS  = 32'h4;
    localparam logic [31:0] GPIO_READ_OFS = 32'h8;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant decision with a last-winner pointer; round-robin or
// fixed master-0 priority on ties.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       winner,
    output logic       any_req
);

    logic last;

    assign any_req = |req;

    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = (FIXED_PRIO != 0) ? 1'b0 : ~last;
            default: winner = 1'b0;
        endcase
    end

    // Resetting to 1 lets master 0 take the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update && any_req) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter and sequencer for the single-slave GPIO bus: one
// bus_valid strobe per grant, read data captured and returned with done.
module gpio_bus_arbiter
    import gpio_bus_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    arb_state_t state;
    logic       owner;
    logic       win;
    logic       any_req;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({m1_req, m0_req}),
        .update  (state == IDLE),
        .winner  (win),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= win;
                        bus_we    <= win ? m1_we    : m0_we;
                        bus_addr  <= win ? m1_addr  : m0_addr;
                        bus_wdata <= win ? m1_wdata : m0_wdata;
                        bus_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus_valid <= 1'b0;
                    state     <= CAPTURE;
                end
                // Slave read data is valid now, one cycle after the strobe.
                CAPTURE: begin
                    if (!bus_we) begin
                        if (owner) m1_rdata <= bus_rdata;
                        else       m0_rdata <= bus_rdata;
                    end
                    m0_done <= ~owner;
                    m1_done <= owner;
                    state   <= DONE;
                end
                DONE: begin
                    m0_done <= 1'b0;
                    m1_done <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
